// File: rtl/bcd_updown_counter_nd.sv
// Cascadable multi-digit modulo-RADIX up/down counter with load clamping and auto-reload.
// Latency: one i_clk edge for reset, load, reload and count; o_dc/o_c are combinational from Q, UP and ET.
// Backpressure: none; i_ep/i_et gate counting, and o_c feeds i_et of the next cascaded stage.
//
// Ports:
//   i_clk   rising-edge clock for all state
//   i_rd    synchronous active-high reset (Q <= 0), highest priority
//   i_ld_n  active-low synchronous load of i_d (digits clamped to RADIX-1)
//   i_ep    parallel count enable
//   i_et    trickle count enable; also gates o_c
//   i_up    direction: 1 = up, 0 = down
//   i_rld   auto-reload enable: at terminal, reload clamped i_d instead of wrapping
//   i_d     load/reload value, digit i at i_d[i*DW +: DW]
//   o_q     count value, digit i at o_q[i*DW +: DW], digit 0 least significant
//   o_dc    per-digit terminal flags for the current direction
//   o_c     ripple carry/borrow: i_et & all digits at terminal
module bcd_updown_counter_nd #(
  parameter int DIGITS = 2,
  parameter int RADIX  = 10,
  parameter int DW     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rd,
  input  logic                 i_ld_n,
  input  logic                 i_ep,
  input  logic                 i_et,
  input  logic                 i_up,
  input  logic                 i_rld,
  input  logic [DIGITS*DW-1:0] i_d,
  output logic [DIGITS*DW-1:0] o_q,
  output logic [DIGITS-1:0]    o_dc,
  output logic                 o_c
);

  // RADIX may equal 2**DW, so the range compare needs one extra bit.
  localparam logic [DW-1:0] MAX_DIGIT = DW'(RADIX - 1);
  localparam logic [DW:0]   RADIX_EXT = (DW+1)'(RADIX);

  if (DIGITS < 1 || RADIX < 2 || RADIX > (1 << DW)) begin : g_bad_params
    $error("bcd_updown_counter_nd: illegal DIGITS/RADIX/DW combination");
  end

  logic [DW-1:0] r_q       [DIGITS];
  logic [DW-1:0] w_d_clamp [DIGITS];
  logic [DW-1:0] w_q_nxt   [DIGITS];
  logic [DIGITS-1:0] w_term;
  // w_lower_term[i] is set when every digit below i sits at its terminal
  // value; it is the per-digit enable of the cascade. Bit DIGITS is "all".
  logic [DIGITS:0]   w_lower_term;
  logic              w_all_term;
  logic              w_ce;
  logic              w_reload;

  assign w_lower_term[0] = 1'b1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign w_term[g] = i_up ? (r_q[g] == MAX_DIGIT) : (r_q[g] == '0);
    assign w_lower_term[g+1] = w_lower_term[g] & w_term[g];
    // Out-of-range load digits saturate so Q never holds an illegal digit.
    assign w_d_clamp[g] = ({1'b0, i_d[g*DW +: DW]} >= RADIX_EXT) ? MAX_DIGIT
                                                                  : i_d[g*DW +: DW];
    assign o_q[g*DW +: DW] = r_q[g];
  end

  assign w_all_term = w_lower_term[DIGITS];
  assign w_ce       = i_ep & i_et & i_ld_n & ~i_rd;
  assign w_reload   = w_ce & i_rld & w_all_term;

  assign o_dc = w_term;
  // Carry ignores EP so a held terminal stage still enables the next stage's
  // trickle input.
  assign o_c  = i_et & w_all_term;

  // Per-digit step, each digit in its own DW-bit arithmetic; wraps at the
  // terminal for the current direction.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      w_q_nxt[i] = r_q[i];
      if (w_lower_term[i]) begin
        if (i_up) begin
          w_q_nxt[i] = w_term[i] ? '0 : r_q[i] + DW'(1);
        end else begin
          w_q_nxt[i] = w_term[i] ? MAX_DIGIT : r_q[i] - DW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DIGITS; i++) begin
      if (i_rd) begin
        r_q[i] <= '0;
      end else if (!i_ld_n) begin
        r_q[i] <= w_d_clamp[i];
      end else if (w_reload) begin
        r_q[i] <= w_d_clamp[i];
      end else if (w_ce) begin
        r_q[i] <= w_q_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_nd.sv
module tb_bcd_updown_counter_nd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: 2 decimal digits
  logic       a_rd, a_ld_n, a_ep, a_et, a_up, a_rld;
  logic [7:0] a_d, a_q;
  logic [1:0] a_dc;
  logic       a_c;
  // Instance B: 3 hex digits
  logic        b_rd, b_ld_n, b_ep, b_et, b_up, b_rld;
  logic [11:0] b_d, b_q;
  logic [2:0]  b_dc;
  logic        b_c;

  bcd_updown_counter_nd #(.DIGITS(2), .RADIX(10), .DW(4)) dut_a (
    .i_clk(clk), .i_rd(a_rd), .i_ld_n(a_ld_n), .i_ep(a_ep), .i_et(a_et),
    .i_up(a_up), .i_rld(a_rld), .i_d(a_d), .o_q(a_q), .o_dc(a_dc), .o_c(a_c)
  );

  bcd_updown_counter_nd #(.DIGITS(3), .RADIX(16), .DW(4)) dut_b (
    .i_clk(clk), .i_rd(b_rd), .i_ld_n(b_ld_n), .i_ep(b_ep), .i_et(b_et),
    .i_up(b_up), .i_rld(b_rld), .i_d(b_d), .o_q(b_q), .o_dc(b_dc), .o_c(b_c)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: counter as a plain integer ----------
  function automatic int modulus(input int radix, input int digits);
    int m = 1;
    for (int i = 0; i < digits; i++) m = m * radix;
    return m;
  endfunction

  function automatic int clamped_value(input int radix, input int digits, input int dw,
                                       input logic [31:0] d);
    int val = 0;
    int w   = 1;
    for (int i = 0; i < digits; i++) begin
      int dig = int'((d >> (i * dw)) & ((32'd1 << dw) - 32'd1));
      if (dig >= radix) dig = radix - 1;
      val = val + dig * w;
      w = w * radix;
    end
    return val;
  endfunction

  function automatic int term_value(input int radix, input int digits, input logic up);
    return up ? modulus(radix, digits) - 1 : 0;
  endfunction

  function automatic int mnext(input int v, input int radix, input int digits, input int dw,
                               input logic rd, input logic ld_n, input logic ep, input logic et,
                               input logic up, input logic rld, input logic [31:0] d);
    int m = modulus(radix, digits);
    if (rd) return 0;
    if (!ld_n) return clamped_value(radix, digits, dw, d);
    if (ep && et) begin
      if (rld && v == term_value(radix, digits, up)) return clamped_value(radix, digits, dw, d);
      return up ? (v + 1) % m : (v + m - 1) % m;
    end
    return v;
  endfunction

  function automatic logic [31:0] to_q(input int v, input int radix, input int digits, input int dw);
    logic [31:0] q = '0;
    int x = v;
    for (int i = 0; i < digits; i++) begin
      q = q | (32'(x % radix) << (i * dw));
      x = x / radix;
    end
    return q;
  endfunction

  function automatic logic [31:0] model_dc(input int v, input int radix, input int digits, input logic up);
    logic [31:0] r = '0;
    int x = v;
    for (int i = 0; i < digits; i++) begin
      if ((x % radix) == (up ? radix - 1 : 0)) r[i] = 1'b1;
      x = x / radix;
    end
    return r;
  endfunction

  int a_v = 0, b_v = 0;
  bit a_valid = 1'b0, b_valid = 1'b0;

  always @(posedge clk) begin
    a_v = mnext(a_v, 10, 2, 4, a_rd, a_ld_n, a_ep, a_et, a_up, a_rld, {24'b0, a_d});
    b_v = mnext(b_v, 16, 3, 4, b_rd, b_ld_n, b_ep, b_et, b_up, b_rld, {20'b0, b_d});
    if (a_rd) a_valid = 1'b1;
    if (b_rd) b_valid = 1'b1;
  end

  // Per-cycle compare, half a period away from the active edge.
  always @(negedge clk) begin
    if (a_valid) begin
      check("a_q_model",  {24'b0, a_q},  to_q(a_v, 10, 2, 4));
      check("a_dc_model", {30'b0, a_dc}, model_dc(a_v, 10, 2, a_up));
      check("a_c_model",  {31'b0, a_c},  {31'b0, a_et && (a_v == term_value(10, 2, a_up))});
    end
    if (b_valid) begin
      check("b_q_model",  {20'b0, b_q},  to_q(b_v, 16, 3, 4));
      check("b_dc_model", {29'b0, b_dc}, model_dc(b_v, 16, 3, b_up));
      check("b_c_model",  {31'b0, b_c},  {31'b0, b_et && (b_v == term_value(16, 3, b_up))});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  logic [7:0] reload_seq [5];

  initial begin
    reload_seq[0] = 8'h96; reload_seq[1] = 8'h97; reload_seq[2] = 8'h98;
    reload_seq[3] = 8'h99; reload_seq[4] = 8'h95;

    a_rd = 1; a_ld_n = 1; a_ep = 0; a_et = 0; a_up = 1; a_rld = 0; a_d = 8'h00;
    b_rd = 1; b_ld_n = 1; b_ep = 0; b_et = 0; b_up = 1; b_rld = 0; b_d = 12'h000;

    // Reset
    tick(2);
    check("rst_a_q", {24'b0, a_q}, 32'h00);
    check("rst_b_q", {20'b0, b_q}, 32'h000);
    check("rst_a_c_et0", {31'b0, a_c}, 32'd0);
    a_et = 1; a_up = 0; #1;
    check("rst_a_c_down", {31'b0, a_c}, 32'd1);
    a_up = 1; #1;
    check("rst_a_c_up", {31'b0, a_c}, 32'd0);

    // Up count 0 -> 99 -> 00
    a_rd = 0; a_ep = 1;
    tick(99);
    check("up99_q", {24'b0, a_q}, 32'h99);
    check("up99_c", {31'b0, a_c}, 32'd1);
    check("up99_dc", {30'b0, a_dc}, 32'b11);
    tick(1);
    check("wrap_q", {24'b0, a_q}, 32'h00);
    check("wrap_c", {31'b0, a_c}, 32'd0);

    // Digit carry and down count
    tick(9);
    check("up09_q", {24'b0, a_q}, 32'h09);
    tick(1);
    check("carry10_q", {24'b0, a_q}, 32'h10);
    a_up = 0;
    tick(1);
    check("borrow09_q", {24'b0, a_q}, 32'h09);
    a_ld_n = 0; a_d = 8'h00;
    tick(1);
    a_ld_n = 1; #1;
    check("down00_c", {31'b0, a_c}, 32'd1);
    tick(1);
    check("downwrap_q", {24'b0, a_q}, 32'h99);

    // Load with clamp; load beats count
    a_ep = 0; a_ld_n = 0; a_d = 8'h3C;
    tick(1);
    check("clamp_q", {24'b0, a_q}, 32'h39);
    a_d = 8'h37; a_ep = 1;
    tick(1);
    check("loadwins_q", {24'b0, a_q}, 32'h37);

    // Enables and carry gating at 99
    a_d = 8'h99;
    tick(1);
    a_ld_n = 1; a_up = 1; a_ep = 0;
    tick(1);
    check("ep0_q", {24'b0, a_q}, 32'h99);
    check("ep0_c", {31'b0, a_c}, 32'd1);
    check("ep0_dc", {30'b0, a_dc}, 32'b11);
    a_et = 0;
    tick(1);
    check("et0_q", {24'b0, a_q}, 32'h99);
    check("et0_c", {31'b0, a_c}, 32'd0);
    check("et0_dc", {30'b0, a_dc}, 32'b11);

    // Auto-reload, period 5
    a_et = 1; a_ep = 1; a_rld = 1; a_ld_n = 0; a_d = 8'h95;
    tick(1);
    a_ld_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("reload_seq", {24'b0, a_q}, {24'b0, reload_seq[i]});
    end
    a_rld = 0; a_ld_n = 0;
    tick(1);
    a_ld_n = 1;
    tick(4);
    check("norld_99", {24'b0, a_q}, 32'h99);
    tick(1);
    check("norld_00", {24'b0, a_q}, 32'h00);

    // Reset beats load
    a_ld_n = 0; a_d = 8'h42;
    tick(1);
    check("load42_q", {24'b0, a_q}, 32'h42);
    a_rd = 1; a_d = 8'h77;
    tick(1);
    check("rdwins_q", {24'b0, a_q}, 32'h00);
    a_rd = 0;
    tick(1);
    check("load77_q", {24'b0, a_q}, 32'h77);
    a_ld_n = 1;

    // 3-digit hex instance
    b_rd = 0; b_ld_n = 0; b_d = 12'hFFF;
    tick(1);
    b_ld_n = 1; b_ep = 1; b_et = 1; b_up = 1; #1;
    check("hex_fff_c", {31'b0, b_c}, 32'd1);
    check("hex_fff_dc", {29'b0, b_dc}, 32'b111);
    tick(1);
    check("hex_wrap_q", {20'b0, b_q}, 32'h000);
    check("hex_wrap_c", {31'b0, b_c}, 32'd0);
    b_up = 0; #1;
    check("hex_down_c", {31'b0, b_c}, 32'd1);
    tick(1);
    check("hex_downwrap_q", {20'b0, b_q}, 32'hFFF);
    b_rd = 1;
    tick(1);
    check("hex_rst_q", {20'b0, b_q}, 32'h000);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter_nd.md
Name: bcd_updown_counter_nd

Overview:
Parametrised, cascadable multi-digit modulo-RADIX counter. It is the next generation of the team's single-decade 4-bit synchronous counter and keeps the same EP/ET enable and ripple-carry semantics. It adds DIGITS-wide cascading, up/down counting, load clamping and an auto-reload (programmable divider) mode. It is used for timebases, display counters and frequency dividers.

Parameters:
DIGITS, 2, number of cascaded digits (>=1)
RADIX, 10, modulus of each digit (2 <= RADIX <= 2**DW)
DW, 4, bits per digit

Ports:
CLK  input  1  single clock; all state changes on its rising edge
RD  input  1  synchronous, active-high reset
_LD  input  1  active-low synchronous parallel load
EP  input  1  count enable (parallel)
ET  input  1  count enable (trickle); also gates C
UP  input  1  direction: 1 = up, 0 = down
RLD  input  1  auto-reload enable
D  input  DIGITS*DW  load/reload value; digit i at D[i*DW +: DW]
Q  output  DIGITS*DW  count value; digit i at Q[i*DW +: DW], digit 0 least significant
DC  output  DIGITS  per-digit terminal flags, combinational: DC[i] = digit i at terminal for current UP
C  output  1  ripple carry/borrow, combinational: ET & all digits at terminal

Behaviour:
- Terminal value: RADIX-1 when UP=1; 0 when UP=0.
- Action priority per CLK edge: RD > load (_LD=0) > reload > count > hold.
- RD=1: Q <= 0 on the edge, regardless of _LD, EP, ET and RLD.
  - No asynchronous effect; Q holds until the edge.
  - While RD is held, Q=0; C = ET & (UP=0), since all-zero is the down terminal.
- Load (_LD=0, RD=0):
  - Q <= D, independent of EP and ET.
  - Each digit with value >= RADIX is clamped to RADIX-1 at load.
  - Q never holds an out-of-range digit.
- Count enable: CE = EP & ET & _LD & ~RD.
- Up count (CE=1, UP=1):
  - Digit i increments when all lower digits equal RADIX-1.
  - RADIX-1 wraps to 0.
  - Digit 0 increments every enabled cycle.
- Down count (CE=1, UP=0):
  - Digit i decrements when all lower digits equal 0.
  - 0 wraps to RADIX-1.
- Full wrap:
  - Up: all-(RADIX-1) -> all-0.
  - Down: all-0 -> all-(RADIX-1).
- Auto-reload (CE=1, RLD=1, all digits at terminal):
  - Q <= clamped D instead of wrapping.
  - Reload period in up mode = RADIX**DIGITS - value(D) cycles.
  - RLD has no effect when not at terminal.
- Hold: CE=0 and no load/reset -> Q unchanged.
- C and DC are combinational from Q and UP; C also depends on ET.
  - C does not depend on EP. When EP=0, ET=1 and the counter is at terminal, C=1 while Q holds.
  - C may glitch when UP changes.
- Changing UP mid-count takes effect on the next edge; no extra state.
- Latency: one CLK edge for reset, load, reload and count. No pipeline.
- Cascading: C of stage n drives ET of stage n+1; all stages share EP and CLK.
- Out-of-range parameters (RADIX > 2**DW or RADIX < 2) are an elaboration error.
- Width rule: per-digit compare/increment in DW bits; no cross-digit binary arithmetic.
- Scale: 120-400 lines RTL.

Test Plan:
- DIGITS=2, RADIX=10, reset/up count: RD=1 for 2 edges -> Q=0x00. Then EP=ET=UP=1 for 99 edges -> Q=0x99, C=1. Next edge -> Q=0x00, C=0.
- Digit carry and down count: from 0x09 up one edge -> 0x10. From 0x00 with UP=0 -> C=1 before the edge; after the edge Q=0x99. From 0x10 down one edge -> 0x09.
- Load and clamp: _LD=0, D=0x3C, EP=0 -> next edge Q=0x39. D=0x37 with EP=ET=1 and _LD=0 -> Q=0x37 (load wins over count).
- Enables and carry gating at Q=0x99, UP=1:
  - EP=0, ET=1 -> Q holds 0x99 and C=1.
  - ET=0 -> Q holds and C=0.
  - DC=2'b11 in both cases.
- Auto-reload: RLD=1, D=0x95, up from 0x95 -> sequence 95,96,97,98,99,95 (period 5). Same with RLD=0 -> 99 -> 00.
- Priority and reset mid-count: at Q=0x42, assert RD=1 with _LD=0, D=0x77 -> Q=0x00. Release RD with _LD=0 -> next edge Q=0x77. Repeat with RADIX=16, DW=4, DIGITS=3: 0xFFF up -> 0x000, C=1 at 0xFFF.
